fm_op_seq: RTL and testbench

Per-sample operator slot sequencer for the FM synth: the driving end of the envelope-generator interface. On each sample tick it walks every operator slot and holds `op_sel` stable for each slot. It strobes `next` to commit per-operator state and delivers queued per-operator resets. It also generates the tremolo `am_val` and forwards each slot's `env`/`restart` result downstream with the operator index.

---
 rtl/fm_op_seq_pkg.sv | 24 ++
 rtl/fm_am_lfo.sv | 32 +++
 rtl/fm_op_seq.sv | 158 +++++++++++++++
 tb/tb_fm_op_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_op_seq_pkg.sv
// Shared constants for the FM operator sequencer: slot count, tremolo LFO shape
// and the envelope stage encodings also used by the EG.
package fm_op_seq_pkg;

  localparam int NUM_OPS_DEF = 36;

  localparam int LFO_POS_LEN = 210;
  localparam int LFO_HALF    = 105;
  localparam int LFO_DIV_MAX = 63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    EG_ATTACK,
    EG_DECAY,
    EG_SUSTAIN,
    EG_RELEASE
  } eg_stage_t;

endpackage

// File: rtl/fm_am_lfo.sv
// Tremolo LFO: 64-frame divider feeding a 210-step triangle, scaled by depth.
module fm_am_lfo
  import fm_op_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       am_depth,
  output logic [5:0] am_val
);

  logic [5:0] r_div;
  logic [7:0] r_pos;
  logic [6:0] w_tri;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_pos <= '0;
    end else if (step) begin
      r_div <= r_div + 6'd1;
      if (r_div == 6'(LFO_DIV_MAX)) begin
        r_pos <= (r_pos == 8'(LFO_POS_LEN - 1)) ? 8'd0 : r_pos + 8'd1;
      end
    end
  end

  // Falling half mirrors the rising half so the peak value (104) is held for two positions.
  assign w_tri  = (r_pos < 8'(LFO_HALF)) ? r_pos[6:0] : 7'(8'(LFO_POS_LEN - 1) - r_pos);
  assign am_val = am_depth ? 6'(w_tri >> 2) : 6'(w_tri >> 4);

endmodule

// File: rtl/fm_op_seq.sv
// Per-sample operator slot sequencer: walks all operator slots once per sample tick,
// strobes next, delivers queued operator resets and forwards each slot's EG result.
module fm_op_seq
  import fm_op_seq_pkg::*;
#(
  parameter int NUM_OPS     = NUM_OPS_DEF,
  parameter int SLOT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rst_req,
  input  logic [5:0] rst_req_op,
  input  logic       am_depth,
  output logic [5:0] op_sel,
  output logic       next,
  output logic       op_reset,
  output logic [5:0] am_val,
  input  logic [8:0] env,
  input  logic       restart,
  output logic [8:0] env_out,
  output logic [5:0] env_out_op,
  output logic       restart_out,
  output logic       env_out_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int SCW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SCW-1:0] SC_LAST  = SCW'(SLOT_CYCLES - 1);
  localparam logic [SCW-1:0] SC_PRE   = SCW'(SLOT_CYCLES - 2);
  localparam logic [5:0]     OP_LAST  = 6'(NUM_OPS - 1);
  localparam logic [6:0]     OP_COUNT = 7'(NUM_OPS);

  seq_state_t     r_state;
  logic [SCW-1:0] r_sc;
  logic [5:0]     r_op_sel;
  logic           r_next;
  logic           r_op_reset;
  logic [5:0]     r_am_val;
  logic [8:0]     r_env_out;
  logic [5:0]     r_env_out_op;
  logic           r_restart_out;
  logic           r_env_out_valid;
  logic           r_busy;
  logic           r_frame_done;
  logic           r_overrun;
  logic [63:0]    r_pending;

  logic [63:0]    w_pending_next;
  logic [5:0]     w_op_inc;
  logic [5:0]     w_lfo_am;
  logic           w_step;

  assign w_op_inc = r_op_sel + 6'd1;
  assign w_step   = (r_state == ST_DONE);

  fm_am_lfo u_lfo (
    .clk      (clk),
    .reset    (reset),
    .step     (w_step),
    .am_depth (am_depth),
    .am_val   (w_lfo_am)
  );

  // Clear before set so a request colliding with its own delivery survives to the next frame.
  always_comb begin
    w_pending_next = r_pending;
    if (r_next && r_op_reset) begin
      w_pending_next[r_op_sel] = 1'b0;
    end
    if (rst_req && ({1'b0, rst_req_op} < OP_COUNT)) begin
      w_pending_next[rst_req_op] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_sc            <= '0;
      r_op_sel        <= '0;
      r_next          <= 1'b0;
      r_op_reset      <= 1'b0;
      r_am_val        <= '0;
      r_env_out       <= '0;
      r_env_out_op    <= '0;
      r_restart_out   <= 1'b0;
      r_env_out_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_done    <= 1'b0;
      r_overrun       <= 1'b0;
      r_pending       <= '0;
    end else begin
      r_pending       <= w_pending_next;
      r_env_out_valid <= r_next;
      r_frame_done    <= 1'b0;
      if (sample_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (sample_tick) begin
            r_state    <= ST_RUN;
            r_busy     <= 1'b1;
            r_sc       <= '0;
            r_op_sel   <= '0;
            r_next     <= 1'b0;
            r_op_reset <= r_pending[0];
            r_am_val   <= w_lfo_am;
          end
        end
        ST_RUN: begin
          if (r_sc == SC_LAST) begin
            r_env_out     <= env;
            r_restart_out <= restart;
            r_env_out_op  <= r_op_sel;
            r_sc          <= '0;
            r_next        <= 1'b0;
            if (r_op_sel == OP_LAST) begin
              r_state      <= ST_DONE;
              r_op_sel     <= '0;
              r_op_reset   <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_op_sel   <= w_op_inc;
              r_op_reset <= r_pending[w_op_inc];
            end
          end else begin
            r_sc   <= r_sc + 1'b1;
            r_next <= (r_sc == SC_PRE);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign op_sel        = r_op_sel;
  assign next          = r_next;
  assign op_reset      = r_op_reset;
  assign am_val        = r_am_val;
  assign env_out       = r_env_out;
  assign env_out_op    = r_env_out_op;
  assign restart_out   = r_restart_out;
  assign env_out_valid = r_env_out_valid;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_fm_op_seq.sv
// Self-checking bench for fm_op_seq: slot-timeline reference model plus directed and random frames,
// and a second small instance for sweeping the full tremolo LFO period.
module tb_fm_op_seq;

  localparam int NOPS = 36;
  localparam int SC   = 4;
  localparam int F    = NOPS * SC + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rst_req = 1'b0;
  logic [5:0] rst_req_op = '0;
  logic       am_depth = 1'b0;
  logic [8:0] env;
  logic       restart;
  logic [5:0] op_sel, am_val, env_out_op;
  logic       next, op_reset, restart_out, env_out_valid, busy, frame_done, overrun;
  logic [8:0] env_out;

  logic       l_tick = 1'b0;
  logic       l_depth = 1'b0;
  logic [5:0] l_op_sel, l_am_val, l_env_out_op;
  logic       l_next, l_op_reset, l_restart_out, l_env_out_valid, l_busy, l_frame_done, l_overrun;
  logic [8:0] l_env_out;

  always #5 clk = ~clk;

  function automatic logic [8:0] eg_env(input logic [5:0] op);
    return 9'(op) * 9'd3;
  endfunction

  function automatic logic eg_rst(input logic [5:0] op);
    return op[0] ^ op[3];
  endfunction

  function automatic logic [5:0] am_of(input int frames, input logic d);
    int pos, tv;
    pos = (frames / 64) % 210;
    tv  = (pos < 105) ? pos : 209 - pos;
    return d ? 6'(tv / 4) : 6'(tv / 16);
  endfunction

  assign env     = eg_env(op_sel);
  assign restart = eg_rst(op_sel);

  fm_op_seq #(.NUM_OPS(NOPS), .SLOT_CYCLES(SC)) u_dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rst_req(rst_req),
    .rst_req_op(rst_req_op), .am_depth(am_depth), .op_sel(op_sel), .next(next),
    .op_reset(op_reset), .am_val(am_val), .env(env), .restart(restart),
    .env_out(env_out), .env_out_op(env_out_op), .restart_out(restart_out),
    .env_out_valid(env_out_valid), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  fm_op_seq #(.NUM_OPS(1), .SLOT_CYCLES(2)) u_lfo_dut (
    .clk(clk), .reset(reset), .sample_tick(l_tick), .rst_req(1'b0),
    .rst_req_op(6'd0), .am_depth(l_depth), .op_sel(l_op_sel), .next(l_next),
    .op_reset(l_op_reset), .am_val(l_am_val), .env(9'd0), .restart(1'b0),
    .env_out(l_env_out), .env_out_op(l_env_out_op), .restart_out(l_restart_out),
    .env_out_valid(l_env_out_valid), .busy(l_busy), .frame_done(l_frame_done), .overrun(l_overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles since frame start (0 = idle, 1..F = frame).
  int         m_t, m_nt, m_slot, m_frames;
  bit         m_isnext, m_oldopr;
  bit [63:0]  m_pend;
  bit         m_opr, m_ovr, m_vld, m_rsto;
  bit [5:0]   m_am, m_eop;
  bit [8:0]   m_env;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0; m_frames = 0; m_pend = '0; m_opr = 0; m_ovr = 0; m_vld = 0;
      m_rsto = 0; m_am = '0; m_eop = '0; m_env = '0;
    end else begin
      m_isnext = (m_t >= 1) && (m_t < F) && ((m_t - 1) % SC == SC - 1);
      m_slot   = (m_t >= 1) ? (m_t - 1) / SC : 0;
      m_oldopr = m_opr;
      m_vld    = m_isnext;
      if (m_isnext) begin
        m_env  = eg_env(6'(m_slot));
        m_rsto = eg_rst(6'(m_slot));
        m_eop  = 6'(m_slot);
      end
      if (sample_tick && m_t != 0) m_ovr = 1;
      if (m_t == 0) m_nt = sample_tick ? 1 : 0;
      else if (m_t == F) m_nt = 0;
      else m_nt = m_t + 1;
      if (m_t == 0 && sample_tick) m_am = am_of(m_frames, am_depth);
      if (m_t == F) m_frames++;
      if (m_nt >= 1 && m_nt < F && ((m_nt - 1) % SC == 0)) m_opr = m_pend[(m_nt - 1) / SC];
      else if (m_nt == 0 || m_nt == F) m_opr = 0;
      if (m_isnext && m_oldopr) m_pend[m_slot] = 0;
      if (rst_req && int'(rst_req_op) < NOPS) m_pend[rst_req_op] = 1;
      m_t = m_nt;
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("busy",          32'(busy),          32'(m_t != 0));
      chk("op_sel",        32'(op_sel),        (m_t >= 1 && m_t < F) ? 32'((m_t - 1) / SC) : 32'd0);
      chk("next",          32'(next),          32'((m_t >= 1) && (m_t < F) && ((m_t - 1) % SC == SC - 1)));
      chk("frame_done",    32'(frame_done),    32'(m_t == F));
      chk("op_reset",      32'(op_reset),      32'(m_opr));
      chk("overrun",       32'(overrun),       32'(m_ovr));
      chk("am_val",        32'(am_val),        32'(m_am));
      chk("env_out_valid", 32'(env_out_valid), 32'(m_vld));
      chk("env_out",       32'(env_out),       32'(m_env));
      chk("env_out_op",    32'(env_out_op),    32'(m_eop));
      chk("restart_out",   32'(restart_out),   32'(m_rsto));
    end
  end

  task automatic frame(input int watch_op, input int inj_lat, input int inj_op, input int tick_lat,
                       output int valids, output int rcnt, output int dlat, output int falls);
    logic pb;
    valids = 0; rcnt = 0; dlat = -1; falls = 0; pb = busy;
    @(posedge clk); #1 sample_tick = 1'b1;
    for (int lat = 1; lat <= 400 && dlat < 0; lat++) begin
      @(posedge clk); #1;
      sample_tick = (lat == tick_lat);
      rst_req     = (lat == inj_lat);
      rst_req_op  = 6'(inj_op);
      @(negedge clk);
      if (env_out_valid) valids++;
      if (op_reset && int'(op_sel) == watch_op) rcnt++;
      if (pb && !busy) falls++;
      pb = busy;
      if (frame_done) dlat = lat;
    end
    sample_tick = 1'b0;
    rst_req = 1'b0;
    if (dlat < 0) chk("frame_done_seen", 32'(frame_done), 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (pb && !busy) falls++;
      pb = busy;
    end
  endtask

  task automatic queue_req(input int op);
    @(posedge clk); #1 rst_req = 1'b1; rst_req_op = 6'(op);
    @(posedge clk); #1 rst_req = 1'b0;
  endtask

  initial begin
    int v, r, d, bf, cnt, pk0, pk1;
    bit found;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_sel", 32'(op_sel), 32'd0);
    chk("rst_am_val", 32'(am_val), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    cmp_en = 1;

    frame(-1, 0, 0, 0, v, r, d, bf);
    chk("t1_valid_count", v, 36);
    chk("t1_done_latency", d, 145);
    chk("t1_last_env", 32'(env_out), 32'd105);
    chk("t1_last_op", 32'(env_out_op), 32'd35);
    $display("frame single: valids=%0d done_lat=%0d", v, d);

    queue_req(5);
    frame(5, 0, 0, 0, v, r, d, bf);
    chk("op5_reset_cycles", r, 4);
    frame(5, 0, 0, 0, v, r, d, bf);
    chk("op5_second_frame", r, 0);
    $display("frame op5 reset checked");

    queue_req(7);
    frame(7, 1 + 7 * SC + SC - 1, 7, 0, v, r, d, bf);
    chk("op7_first_delivery", r, 4);
    frame(7, 0, 0, 0, v, r, d, bf);
    chk("op7_redelivered", r, 4);
    frame(7, 0, 0, 0, v, r, d, bf);
    chk("op7_cleared", r, 0);
    $display("frame op7 collision checked");

    queue_req(40);
    frame(-1, 0, 0, 50, v, r, d, bf);
    chk("ovr_done_latency", d, 145);
    chk("ovr_busy_falls", bf, 1);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    $display("frame overrun: busy_falls=%0d", bf);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      sample_tick = ($urandom_range(0, 39) == 0);
      rst_req     = ($urandom_range(0, 5) == 0);
      rst_req_op  = 6'($urandom_range(0, 63));
      am_depth    = 1'($urandom_range(0, 1));
    end
    #1 sample_tick = 1'b0; rst_req = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (busy && cnt < 300);
    chk("rand_idle", 32'(busy), 32'd0);
    $display("random phase done");

    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (op_sel == 6'd20) found = 1;
    end
    chk("reached_slot20", 32'(op_sel), 32'd20);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("async_rst_a", {26'd0, op_sel}, 32'd0);
    chk("async_rst_b", {next, op_reset, am_val, env_out, env_out_op, restart_out,
                        env_out_valid, busy, frame_done, overrun}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    cnt = 0;
    repeat (200) begin @(negedge clk); if (frame_done) cnt++; end
    chk("no_done_after_reset", cnt, 0);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    @(negedge clk);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_op_sel", 32'(op_sel), 32'd0);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!frame_done && cnt < 300);
    chk("restart_done", 32'(frame_done), 32'd1);
    chk("restart_no_overrun", 32'(overrun), 32'd0);
    $display("frame reset mid-frame checked");

    pk0 = 0; pk1 = 0;
    for (int f = 0; f <= 64 * 210; f++) begin
      @(posedge clk); #1;
      l_tick  = 1'b1;
      l_depth = 1'($urandom_range(0, 1));
      @(posedge clk); #1 l_tick = 1'b0;
      @(negedge clk);
      chk("lfo_am_val", 32'(l_am_val), 32'(am_of(f, l_depth)));
      if (l_depth && int'(l_am_val) > pk1) pk1 = int'(l_am_val);
      if (!l_depth && int'(l_am_val) > pk0) pk0 = int'(l_am_val);
      cnt = 0;
      while (!l_frame_done && cnt < 10) begin @(negedge clk); cnt++; end
      if (cnt >= 10) chk("lfo_frame_done", 32'(l_frame_done), 32'd1);
      if (f % 2100 == 0) $display("lfo frame %0d: am_val=%0d depth=%0d", f, l_am_val, l_depth);
    end
    chk("lfo_peak_deep", pk1, 26);
    chk("lfo_peak_shallow", pk0, 6);
    chk("lfo_wrapped_zero", 32'(l_am_val), 32'd0);

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
